// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB-first, one bit per clock.
// Optional subtract mode under `define SERIAL_ADDER_SUB_EN (adds the sub input port).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_comb begin
        bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
        bit_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_next = {bit_s, res_sh[WIDTH-1:1]};
    end

    // Subtraction is a + ~b + 1, so only the loaded operand and initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load     = b;
        carry_load = cin;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_next;
                    carry  <= bit_c;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // sum/cout are only touched here, so they hold the last result mid-operation
                        sum   <= res_next;
                        cout  <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
